// File: rtl/scratch_bist.sv
// March-style BIST for the 256x10 scratch RAM: write/read PAT_A, then write/read ~PAT_A.
// Reports a sticky fail flag, first-failure capture and a total mismatch count.
module scratch_bist #(
    parameter logic [9:0] PAT_A = 10'h0FC
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    output logic [7:0] BIST_ADDR,
    output logic [9:0] BIST_DATA,
    output logic       BIST_WE,
    input  logic [9:0] RAM_DATA,
    output logic       BUSY,
    output logic       DONE,
    output logic       FAIL,
    output logic [7:0] FAIL_ADDR,
    output logic [9:0] FAIL_DATA,
    output logic       FAIL_PHASE,
    output logic [9:0] ERR_COUNT
);
    localparam logic [9:0] PAT_B = ~PAT_A;

    typedef enum logic [2:0] {
        S_IDLE, S_WR_A, S_RD_A, S_WR_B, S_RD_B, S_DONE
    } state_t;

    state_t     state, next_state;
    logic [7:0] addr_cnt;
    logic       last_addr;
    logic       start_ok;
    logic       rd_phase;
    logic       mismatch;

    assign last_addr = (addr_cnt == 8'hFF);
    assign start_ok  = START && (state == S_IDLE || state == S_DONE);
    assign rd_phase  = (state == S_RD_A) || (state == S_RD_B);
    // RAM read is combinational, so compare against the pattern driven this cycle
    assign mismatch  = rd_phase && (RAM_DATA != BIST_DATA);

    always_ff @(posedge CLK) begin
        if (RST)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (START) next_state = S_WR_A;
            S_WR_A:  if (last_addr) next_state = S_RD_A;
            S_RD_A:  if (last_addr) next_state = S_WR_B;
            S_WR_B:  if (last_addr) next_state = S_RD_B;
            S_RD_B:  if (last_addr) next_state = S_DONE;
            S_DONE:  if (START) next_state = S_WR_A;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        BIST_ADDR = addr_cnt;
        BIST_DATA = 10'd0;
        BIST_WE   = 1'b0;
        BUSY      = 1'b0;
        DONE      = 1'b0;
        case (state)
            S_WR_A: begin BIST_DATA = PAT_A; BIST_WE = 1'b1; BUSY = 1'b1; end
            S_RD_A: begin BIST_DATA = PAT_A; BUSY = 1'b1; end
            S_WR_B: begin BIST_DATA = PAT_B; BIST_WE = 1'b1; BUSY = 1'b1; end
            S_RD_B: begin BIST_DATA = PAT_B; BUSY = 1'b1; end
            S_DONE: DONE = 1'b1;
            default: ;
        endcase
    end

    // Counter wraps naturally at 255, which lines up with each phase change
    always_ff @(posedge CLK) begin
        if (RST || start_ok) begin
            addr_cnt   <= 8'd0;
            FAIL       <= 1'b0;
            FAIL_ADDR  <= 8'd0;
            FAIL_DATA  <= 10'd0;
            FAIL_PHASE <= 1'b0;
            ERR_COUNT  <= 10'd0;
        end else begin
            if (BUSY)
                addr_cnt <= addr_cnt + 8'd1;
            if (mismatch) begin
                ERR_COUNT <= ERR_COUNT + 10'd1;
                if (!FAIL) begin
                    FAIL       <= 1'b1;
                    FAIL_ADDR  <= addr_cnt;
                    FAIL_DATA  <= RAM_DATA;
                    FAIL_PHASE <= (state == S_RD_B);
                end
            end
        end
    end
endmodule

// File: tb/tb_scratch_bist.sv
// Bench for scratch_bist: faulty RAM model, march reference model and a DONE-triggered scoreboard.
// Note: a single-pattern march cannot detect address aliasing, so that run must report no errors.
module tb_scratch_bist;
    localparam logic [9:0] PAT_A = 10'h0FC;
    localparam logic [9:0] PAT_B = ~PAT_A;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic [7:0] BIST_ADDR;
    logic [9:0] BIST_DATA;
    logic       BIST_WE;
    logic [9:0] RAM_DATA;
    logic       BUSY, DONE, FAIL, FAIL_PHASE;
    logic [7:0] FAIL_ADDR;
    logic [9:0] FAIL_DATA, ERR_COUNT;

    scratch_bist #(.PAT_A(PAT_A)) dut (
        .CLK(CLK), .RST(RST), .START(START),
        .BIST_ADDR(BIST_ADDR), .BIST_DATA(BIST_DATA), .BIST_WE(BIST_WE),
        .RAM_DATA(RAM_DATA), .BUSY(BUSY), .DONE(DONE), .FAIL(FAIL),
        .FAIL_ADDR(FAIL_ADDR), .FAIL_DATA(FAIL_DATA), .FAIL_PHASE(FAIL_PHASE),
        .ERR_COUNT(ERR_COUNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       fail;
        logic [7:0] addr;
        logic [9:0] data;
        logic       phase;
        int         err;
        longint     done_cyc;
    } exp_t;

    exp_t   sbq[$];
    int     checks = 0;
    int     failures = 0;
    longint cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // RAM model with injectable faults
    logic       f_alias = 1'b0, f_stuck = 1'b0, f_all = 1'b0, f_val = 1'b0;
    logic [7:0] f_addr = 8'd0;
    logic [9:0] f_mask = 10'd0;
    logic       ram_fill = 1'b0;
    logic [9:0] ram [256];
    logic [7:0] ram_pa;

    always_comb begin
        ram_pa   = f_alias ? {1'b0, BIST_ADDR[6:0]} : BIST_ADDR;
        RAM_DATA = ram[ram_pa];
        if (f_stuck && (f_all || BIST_ADDR == f_addr))
            RAM_DATA = f_val ? (RAM_DATA | f_mask) : (RAM_DATA & ~f_mask);
    end

    always @(posedge CLK) begin
        if (ram_fill) begin
            for (int i = 0; i < 256; i++) ram[i] <= 10'($urandom);
        end else if (BIST_WE) begin
            ram[ram_pa] <= BIST_DATA;
        end
    end

    // Reference: the whole march expressed as loops over an array
    logic [9:0] ref_mem [256];

    function automatic logic [7:0] phys(input logic [7:0] a);
        return f_alias ? {1'b0, a[6:0]} : a;
    endfunction

    function automatic logic [9:0] rd_fault(input logic [7:0] a, input logic [9:0] d);
        if (f_stuck && (f_all || a == f_addr))
            return f_val ? (d | f_mask) : (d & ~f_mask);
        return d;
    endfunction

    task automatic ref_run(input longint done_at, output exp_t e);
        logic [9:0] pat, d;
        e.fail = 0; e.addr = 0; e.data = 0; e.phase = 0; e.err = 0;
        e.done_cyc = done_at;
        for (int p = 0; p < 2; p++) begin
            pat = (p == 0) ? PAT_A : PAT_B;
            for (int a = 0; a < 256; a++) ref_mem[phys(8'(a))] = pat;
            for (int a = 0; a < 256; a++) begin
                d = rd_fault(8'(a), ref_mem[phys(8'(a))]);
                if (d != pat) begin
                    if (!e.fail) begin
                        e.fail = 1; e.addr = 8'(a); e.data = d; e.phase = (p == 1);
                    end
                    e.err++;
                end
            end
        end
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Monitor: on each DONE rising edge pop the oldest expectation and compare
    exp_t mon_e;
    int   busy_cnt = 0;
    logic done_q = 1'b0;

    always @(negedge CLK) begin
        if (BUSY) busy_cnt++;
        if (DONE && !done_q) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_e = sbq.pop_front();
                chk("sb_done_cycle", cyc, mon_e.done_cyc);
                chk("sb_busy_cycles", busy_cnt, 1024);
                chk("sb_fail", FAIL, mon_e.fail);
                chk("sb_fail_addr", FAIL_ADDR, mon_e.addr);
                chk("sb_fail_data", FAIL_DATA, mon_e.data);
                chk("sb_fail_phase", FAIL_PHASE, mon_e.phase);
                chk("sb_err_count", ERR_COUNT, mon_e.err);
            end
            busy_cnt = 0;
        end
        if (!BUSY && !DONE) busy_cnt = 0;
        done_q = DONE;
    end

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_addr"}, BIST_ADDR, 0);
        chk({nm, "_data"}, BIST_DATA, 0);
        chk({nm, "_we"}, BIST_WE, 0);
        chk({nm, "_busy"}, BUSY, 0);
        chk({nm, "_done"}, DONE, 0);
        chk({nm, "_fail"}, FAIL, 0);
        chk({nm, "_fail_addr"}, FAIL_ADDR, 0);
        chk({nm, "_fail_data"}, FAIL_DATA, 0);
        chk({nm, "_fail_phase"}, FAIL_PHASE, 0);
        chk({nm, "_err"}, ERR_COUNT, 0);
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (DONE !== 1'b1 && n < 1100) begin
            @(negedge CLK);
            n++;
        end
        chk({nm, "_done_seen"}, DONE, 1);
    endtask

    task automatic start_run(input string nm, output longint s);
        @(negedge CLK);
        ref_mem = ram;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        s = cyc;
        chk({nm, "_st_busy"}, BUSY, 1);
        chk({nm, "_st_we"}, BIST_WE, 1);
        chk({nm, "_st_data"}, BIST_DATA, PAT_A);
        chk({nm, "_st_addr"}, BIST_ADDR, 0);
        chk({nm, "_st_fail_clr"}, FAIL, 0);
        chk({nm, "_st_err_clr"}, ERR_COUNT, 0);
    endtask

    task automatic run(input string nm, input int repulse, input int rst_at);
        exp_t   e;
        longint s;
        start_run(nm, s);
        ref_run(s + 1024, e);
        if (rst_at == 0) sbq.push_back(e);
        if (repulse > 0) begin
            while (cyc - s < repulse - 1) @(negedge CLK);
            START = 1'b1;
            @(posedge CLK);
            #1;
            START = 1'b0;
            chk({nm, "_repulse_busy"}, BUSY, 1);
        end
        if (rst_at > 0) begin
            while (cyc - s < rst_at - 1) @(negedge CLK);
            RST = 1'b1;
            @(posedge CLK);
            #1;
            RST = 1'b0;
            @(negedge CLK);
            chk_reset_vals({nm, "_rst"});
        end else begin
            wait_done(nm);
        end
    endtask

    task automatic clear_faults();
        f_alias = 0; f_stuck = 0; f_all = 0; f_val = 0; f_addr = 0; f_mask = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t   e1, e2;
        longint s;
        int     bad;

        ram_fill = 1'b1;
        @(posedge CLK);
        #1;
        ram_fill = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk_reset_vals("reset");
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        chk_reset_vals("idle");

        run("clean", 0, 0);
        bad = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== 10'h303) bad++;
        chk("clean_ram_303", bad, 0);
        chk("clean_fail", FAIL, 0);

        f_stuck = 1; f_addr = 8'h37; f_mask = 10'h001; f_val = 1;
        run("stuck37", 0, 0);
        chk("stuck37_fail", FAIL, 1);
        chk("stuck37_addr", FAIL_ADDR, 8'h37);
        chk("stuck37_data", FAIL_DATA, 10'h0FD);
        chk("stuck37_phase", FAIL_PHASE, 0);
        chk("stuck37_err", ERR_COUNT, 1);

        clear_faults();
        run("restart_clean", 0, 0);
        chk("restart_clean_fail", FAIL, 0);

        f_alias = 1;
        run("alias", 0, 0);
        chk("alias_err", ERR_COUNT, 0);

        clear_faults();
        f_stuck = 1; f_all = 1; f_mask = 10'h200; f_val = 0;
        run("bit9", 0, 0);
        chk("bit9_addr", FAIL_ADDR, 8'h00);
        chk("bit9_phase", FAIL_PHASE, 1);
        chk("bit9_data", FAIL_DATA, 10'h103);
        chk("bit9_err", ERR_COUNT, 256);

        clear_faults();
        run("repulse", 300, 0);
        run("rst600", 0, 600);
        run("after_rst", 0, 0);
        chk("after_rst_fail", FAIL, 0);

        for (int r = 0; r < 4; r++) begin
            clear_faults();
            f_stuck = 1;
            f_addr  = 8'($urandom);
            f_mask  = 10'(1 << $urandom_range(0, 9));
            f_val   = 1'($urandom);
            repeat ($urandom_range(0, 20)) @(negedge CLK);
            run("random", 0, 0);
        end

        clear_faults();
        f_stuck = 1; f_addr = 8'($urandom); f_mask = 10'h010; f_val = 0;
        @(negedge CLK);
        ref_mem = ram;
        START = 1'b1;
        @(posedge CLK);
        #1;
        s = cyc;
        ref_run(s + 1024, e1);
        sbq.push_back(e1);
        ref_run(s + 2049, e2);
        sbq.push_back(e2);
        wait_done("held1");
        @(posedge CLK);
        #1;
        START = 1'b0;
        chk("held_restart_busy", BUSY, 1);
        wait_done("held2");

        repeat (2) @(negedge CLK);
        chk("sb_queue_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/scratch_bist.md
# scratch_bist

Built-in self-test controller that exercises the 256 x 10 scratch RAM as its only master during test, then reports pass/fail. It writes a fixed pattern to every address, reads each one back and compares it, then repeats with the bitwise complement. It sits between the MCU top level and the scratch RAM port, and the top-level mux hands it the RAM while `BUSY` is high. Results stay held until the next start or reset.

## Interface
Parameters:
- `PAT_A`, default `10'h0FC`: first-pass pattern. The second pass uses `PAT_B = ~PAT_A` (`10'h303` by default).

Ports:
- `CLK`  in  1: single clock; all state updates on the rising edge.
- `RST`  in  1: synchronous, active-high reset.
- `START`  in  1: begin a test run. Sampled only in IDLE or DONE.
- `BIST_ADDR`  out  8: address to the RAM `SCR_ADDR` input.
- `BIST_DATA`  out  10: write data to the RAM `DATA_IN` input.
- `BIST_WE`  out  1: write enable to the RAM `SCR_WE` input.
- `RAM_DATA`  in  10: RAM `DATA_OUT`. The RAM read is combinational from `SCR_ADDR`; the RAM writes on the rising edge.
- `BUSY`  out  1: high while a run is in progress.
- `DONE`  out  1: high once a run completes; held.
- `FAIL`  out  1: sticky; set on any read mismatch.
- `FAIL_ADDR`  out  8: address of the first mismatch.
- `FAIL_DATA`  out  10: data read at the first mismatch.
- `FAIL_PHASE`  out  1: phase of the first mismatch; 0 = RD_A, 1 = RD_B.
- `ERR_COUNT`  out  10: total mismatches in the run (range 0..512; no saturation needed).

## Operation
States: IDLE, WR_A, RD_A, WR_B, RD_B, DONE.

Transitions:
- IDLE or DONE, with `START`=1 → WR_A. On the same edge: address counter := 0; `FAIL`, `FAIL_*` and `ERR_COUNT` clear; `DONE` := 0.
- In WR_A, RD_A, WR_B and RD_B, the 8-bit address counter increments every cycle.
- When the counter is 255 in a phase, the counter wraps to 0 and the state advances: WR_A→RD_A→WR_B→RD_B→DONE.
- DONE holds until `START` or `RST`.

Output decode (from the state and counter registers, no extra pipeline):
- `BIST_ADDR` = counter.
- `BIST_WE` = 1 in WR_A and WR_B only.
- `BIST_DATA` = `PAT_A` in WR_A/RD_A, `PAT_B` in WR_B/RD_B. Value in IDLE/DONE is don't-care; drive 0.
- `BUSY` = 1 in the four active states.
- `DONE` = 1 in the DONE state.

Compare:
- In RD_A/RD_B, a mismatch is `RAM_DATA != expected` in the cycle the address is presented.
- On a mismatch, `ERR_COUNT` increments at that edge.
- If `FAIL` is still 0 at a mismatch: `FAIL` := 1 and `FAIL_ADDR`, `FAIL_DATA`, `FAIL_PHASE` are captured. Later mismatches leave the captured values unchanged.

Boundary cases:
- `START` while `BUSY`: ignored.
- `START` held high continuously: a new run starts each time DONE is reached.
- `RST` mid-run: the controller returns to IDLE on that edge and all outputs take reset values. RAM contents are left as-is (not restored).
- `RST` and `START` both high: `RST` wins.

## Timing
- Reset values: state IDLE, counter 0. `BIST_ADDR`=0, `BIST_DATA`=0, `BIST_WE`=0, `BUSY`=0, `DONE`=0, `FAIL`=0, `FAIL_ADDR`=0, `FAIL_DATA`=0, `FAIL_PHASE`=0, `ERR_COUNT`=0.
- Number cycles from edge 0, the edge on which `START` is sampled:
  - WR_A drives addresses 0..255 during cycles 1..256.
  - RD_A drives 0..255 during cycles 257..512.
  - WR_B drives 0..255 during cycles 513..768.
  - RD_B drives 0..255 during cycles 769..1024.
  - `DONE`=1 and `BUSY`=0 from cycle 1025.
- Run length is fixed at 1024 busy cycles, independent of faults.
- A write in the last WR cycle lands on the edge that enters RD. Address 0 was written 256 cycles earlier, so there is no read-after-write hazard.
- `FAIL` and `ERR_COUNT` update one edge after the offending read cycle.

## Test plan
- Fault-free RAM model, `START` pulse → `BUSY` for 1024 cycles; `DONE` at cycle 1025; `FAIL`=0, `ERR_COUNT`=0; RAM holds `10'h303` everywhere.
- Model with bit 0 stuck at 1 at address `8'h37` → `FAIL`=1, `FAIL_ADDR`=`8'h37`, `FAIL_DATA`=`10'h0FD`, `FAIL_PHASE`=0, `ERR_COUNT`=1.
- Model with address bit 7 tied to 0 (aliasing) → first fail at `FAIL_ADDR`=`8'h00`, `FAIL_PHASE`=0 is not expected; instead all reads pass in RD_A. Check `ERR_COUNT`=0 and document that a single-pattern march cannot detect aliasing. Also add a model with bit 9 stuck at 0 everywhere → first fail at `FAIL_ADDR`=0, `FAIL_PHASE`=1, `FAIL_DATA`=`10'h103`, `ERR_COUNT`=256.
- `START` re-pulsed at cycle 300 → ignored; `DONE` still at cycle 1025.
- `RST` at cycle 600 → next cycle all outputs at reset values and state IDLE. A new `START` then runs a full 1024 cycles with clean results.
- After a failing run, `START` from DONE → `FAIL`, `FAIL_*` and `ERR_COUNT` cleared on the start edge. With a fault-free model, the run ends with `FAIL`=0.
